// File: rtl/datapath_pipe.sv
// Two-stage ALU datapath: issue (register read, forward, shift) then execute/commit,
// with an iterative shift-add multiplier.
//   state    | meaning
//   RUN      | accepts one issue per cycle; single-cycle ops complete the next cycle
//   MUL_BUSY | shift-add multiply in progress, one multiplier bit per cycle, issue stalled
module datapath_pipe #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    localparam int AW = $clog2(NREGS),
    localparam int SW = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     A_addr,
    input  logic [AW-1:0]     B_addr,
    input  logic [AW-1:0]     w_addr,
    input  logic [2:0]        ALU_op,
    input  logic [1:0]        shift_op,
    input  logic [SW-1:0]     shift_amt,
    input  logic              sel_B,
    input  logic [DATA_W-1:0] imme_data,
    input  logic              w_en,
    input  logic              en_status,
    output logic              out_valid,
    output logic [DATA_W-1:0] datapath_out,
    output logic [3:0]        status_out,
    input  logic [AW-1:0]     reg_addr,
    output logic [DATA_W-1:0] reg_output
);

    typedef enum logic {RUN = 1'b0, MUL_BUSY = 1'b1} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   regs_d [NREGS];
    logic [3:0]          status_q, status_d;
    logic                ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0]   ex_a_q, ex_a_d;
    logic [DATA_W-1:0]   ex_b_q, ex_b_d;
    logic [2:0]          ex_op_q, ex_op_d;
    logic [AW-1:0]       ex_waddr_q, ex_waddr_d;
    logic                ex_wen_q, ex_wen_d;
    logic                ex_stat_q, ex_stat_d;
    logic [DATA_W-1:0]   mul_acc_q, mul_acc_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [SW-1:0]       cnt_q, cnt_d;

    logic                accept;
    logic                is_sub;
    logic [DATA_W-1:0]   addend;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   result;
    logic                res_c, res_v;
    logic                commit_wr, commit_flags;
    logic [DATA_W-1:0]   a_src, b_reg, b_shift, b_src;
    logic [2*DATA_W-1:0] b_rot;

    assign in_ready = (state_q == RUN);
    assign accept   = in_valid && in_ready;

    // Execute stage; logical ops and MUL leave C/V at their current values.
    always_comb begin
        is_sub = (ex_op_q == OP_SUB) || (ex_op_q == OP_CMP);
        addend = is_sub ? ~ex_b_q : ex_b_q;
        sum    = {1'b0, ex_a_q} + {1'b0, addend} + {{DATA_W{1'b0}}, is_sub};
        result = mul_acc_q;
        res_c  = status_q[1];
        res_v  = status_q[0];
        case (ex_op_q)
            OP_ADD, OP_SUB, OP_CMP: begin
                result = sum[DATA_W-1:0];
                res_c  = sum[DATA_W];
                res_v  = (ex_a_q[DATA_W-1] == addend[DATA_W-1]) &&
                         (sum[DATA_W-1] != ex_a_q[DATA_W-1]);
            end
            OP_AND:  result = ex_a_q & ex_b_q;
            OP_ORR:  result = ex_a_q | ex_b_q;
            OP_EOR:  result = ex_a_q ^ ex_b_q;
            OP_MOV:  result = ex_b_q;
            default: result = mul_acc_q;
        endcase
    end

    assign commit_wr    = ex_valid_q && ex_wen_q && (ex_op_q != OP_CMP);
    assign commit_flags = ex_valid_q && (ex_stat_q || (ex_op_q == OP_CMP));

    // Sources bypass the register file when the same edge commits to them.
    always_comb begin
        a_src = (commit_wr && (ex_waddr_q == A_addr)) ? result : regs_q[A_addr];
        b_reg = (commit_wr && (ex_waddr_q == B_addr)) ? result : regs_q[B_addr];
        b_rot = {b_reg, b_reg} >> shift_amt;
        case (shift_op)
            2'b00:   b_shift = b_reg << shift_amt;
            2'b01:   b_shift = b_reg >> shift_amt;
            2'b10:   b_shift = $signed(b_reg) >>> shift_amt;
            default: b_shift = b_rot[DATA_W-1:0];
        endcase
        b_src = sel_B ? imme_data : b_shift;
    end

    always_comb begin
        state_d    = state_q;
        regs_d     = regs_q;
        status_d   = status_q;
        ex_valid_d = 1'b0;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_op_d    = ex_op_q;
        ex_waddr_d = ex_waddr_q;
        ex_wen_d   = ex_wen_q;
        ex_stat_d  = ex_stat_q;
        mul_acc_d  = mul_acc_q;
        dout_d     = dout_q;
        cnt_d      = cnt_q;

        if (ex_valid_q) dout_d = result;
        if (commit_wr) regs_d[ex_waddr_q] = result;
        if (commit_flags) status_d = {result[DATA_W-1], result == '0, res_c, res_v};

        case (state_q)
            RUN: begin
                if (accept) begin
                    ex_op_d    = ALU_op;
                    ex_waddr_d = w_addr;
                    ex_wen_d   = w_en;
                    ex_stat_d  = en_status;
                    if (ALU_op == OP_MUL) begin
                        // Bit 0 of the multiplier is consumed on the issue edge.
                        state_d   = MUL_BUSY;
                        mul_acc_d = b_src[0] ? a_src : '0;
                        ex_a_d    = a_src << 1;
                        ex_b_d    = b_src >> 1;
                        cnt_d     = SW'(1);
                    end else begin
                        ex_a_d     = a_src;
                        ex_b_d     = b_src;
                        ex_valid_d = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                if (ex_b_q[0]) mul_acc_d = mul_acc_q + ex_a_q;
                ex_a_d = ex_a_q << 1;
                ex_b_d = ex_b_q >> 1;
                if (cnt_q == SW'(DATA_W-1)) begin
                    state_d    = RUN;
                    ex_valid_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            status_q   <= 4'b0000;
            ex_valid_q <= 1'b0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_op_q    <= OP_ADD;
            ex_waddr_q <= '0;
            ex_wen_q   <= 1'b0;
            ex_stat_q  <= 1'b0;
            mul_acc_q  <= '0;
            dout_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            regs_q     <= regs_d;
            status_q   <= status_d;
            ex_valid_q <= ex_valid_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_op_q    <= ex_op_d;
            ex_waddr_q <= ex_waddr_d;
            ex_wen_q   <= ex_wen_d;
            ex_stat_q  <= ex_stat_d;
            mul_acc_q  <= mul_acc_d;
            dout_q     <= dout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid    = ex_valid_q;
    assign datapath_out = ex_valid_q ? result : dout_q;
    assign status_out   = status_q;
    assign reg_output   = regs_q[reg_addr];

endmodule

// File: tb/tb_datapath_pipe.sv
// Self-checking bench for datapath_pipe: directed scenarios plus random programs
// compared against an in-order architectural model.
module tb_datapath_pipe;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_ORR = 3'd3;
    localparam logic [2:0] OP_EOR = 3'd4, OP_MOV = 3'd5, OP_CMP = 3'd6, OP_MUL = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  A_addr = '0, B_addr = '0, w_addr = '0, reg_addr = '0;
    logic [2:0]  ALU_op = '0;
    logic [1:0]  shift_op = '0;
    logic [4:0]  shift_amt = '0;
    logic        sel_B = 1'b0, w_en = 1'b0, en_status = 1'b0;
    logic [31:0] imme_data = '0;
    logic        out_valid;
    logic [31:0] datapath_out, reg_output;
    logic [3:0]  status_out;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_regs [16];
    logic [3:0]  m_flags;

    always #5 clk = ~clk;

    datapath_pipe #(.DATA_W(32), .NREGS(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A_addr(A_addr), .B_addr(B_addr), .w_addr(w_addr), .ALU_op(ALU_op),
        .shift_op(shift_op), .shift_amt(shift_amt), .sel_B(sel_B), .imme_data(imme_data),
        .w_en(w_en), .en_status(en_status), .out_valid(out_valid),
        .datapath_out(datapath_out), .status_out(status_out),
        .reg_addr(reg_addr), .reg_output(reg_output)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (architectural, in program order) ----------------
    function automatic logic [31:0] shift_ref(input logic [31:0] b, input logic [1:0] sop, input int amt);
        logic [31:0] r;
        r = b;
        for (int i = 0; i < amt; i++) begin
            case (sop)
                2'd0:    r = {r[30:0], 1'b0};
                2'd1:    r = {1'b0, r[31:1]};
                2'd2:    r = {r[31], r[31:1]};
                default: r = {r[0], r[31:1]};
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_exec(input logic [2:0] op, input int wa, input int aa, input int ba,
                                             input logic [1:0] sop, input int samt, input logic sel,
                                             input logic [31:0] imm, input logic we, input logic es);
        logic [31:0] a, b, res;
        logic [63:0] wide;
        logic        c, v;
        longint      sa, sbv, sr;
        a   = m_regs[aa];
        b   = sel ? imm : shift_ref(m_regs[ba], sop, samt);
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        c   = m_flags[1];
        v   = m_flags[0];
        res = '0;
        case (op)
            OP_ADD: begin
                wide = 64'(a) + 64'(b);
                res  = wide[31:0];
                c    = wide[32];
                sr   = sa + sbv;
                v    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            OP_SUB, OP_CMP: begin
                res = a - b;
                c   = (a >= b);
                sr  = sa - sbv;
                v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            OP_AND: res = a & b;
            OP_ORR: res = a | b;
            OP_EOR: res = a ^ b;
            OP_MOV: res = b;
            default: begin
                wide = 64'(a) * 64'(b);
                res  = wide[31:0];
            end
        endcase
        if (es || op == OP_CMP) m_flags = {res[31], res == 32'd0, c, v};
        if (we && op != OP_CMP) m_regs[wa] = res;
        return res;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_flags = 4'b0000;
    endtask

    // ---------------- driver: call just after a negedge, returns at the completion cycle ----------------
    task automatic do_op(input logic [2:0] op, input int wa, input int aa, input int ba,
                         input logic [1:0] sop, input int samt, input logic sel, input logic [31:0] imm,
                         input logic we, input logic es,
                         output int lat, output logic [31:0] dout, output int busy_bad);
        int guard;
        ALU_op = op; w_addr = 4'(wa); A_addr = 4'(aa); B_addr = 4'(ba);
        shift_op = sop; shift_amt = 5'(samt); sel_B = sel; imme_data = imm;
        w_en = we; en_status = es; in_valid = 1'b1;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        busy_bad = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) busy_bad++;
            @(negedge clk);
            lat++;
        end
        dout = datapath_out;
    endtask

    task automatic step(input logic [2:0] op, input int wa, input int aa, input int ba,
                        input logic [1:0] sop, input int samt, input logic sel, input logic [31:0] imm,
                        input logic we, input logic es,
                        output logic [31:0] dout, output logic [31:0] exp, output int lat, output int busy_bad);
        do_op(op, wa, aa, ba, sop, samt, sel, imm, we, es, lat, dout, busy_bad);
        exp = ref_exec(op, wa, aa, ba, sop, samt, sel, imm, we, es);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1; ALU_op = OP_ADD; w_en = 1'b1; en_status = 1'b1;
        sel_B = 1'b1; imme_data = $urandom; w_addr = 4'(2);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        model_reset();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++; if (status_out !== 4'b0000) begin n_err++; $display("FAIL reset_status: got %b want 0000", status_out); end
        n_vec++; if (datapath_out !== 32'd0) begin n_err++; $display("FAIL reset_dout: got %h want 0", datapath_out); end
        for (int i = 0; i < 16; i++) begin
            reg_addr = 4'(i);
            #1;
            n_vec++;
            if (reg_output !== 32'd0) begin n_err++; $display("FAIL reset_reg%0d: got %h want 0", i, reg_output); end
            @(negedge clk);
        end
    endtask

    task automatic test_forwarding();
        logic [31:0] d, e;
        int lat, bb;
        step(OP_MOV, 1, 0, 0, 2'd0, 0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, d, e, lat, bb);
        n_vec++; if (d !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL fwd_mov: got %h want 7fffffff", d); end
        step(OP_ADD, 2, 1, 0, 2'd0, 0, 1'b1, 32'd1, 1'b1, 1'b1, d, e, lat, bb);
        n_vec++; if (d !== 32'h8000_0000) begin n_err++; $display("FAIL fwd_add: got %h want 80000000", d); end
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL fwd_latency: got %0d want 1", lat); end
        @(negedge clk);
        n_vec++; if (status_out !== 4'b1001) begin n_err++; $display("FAIL fwd_flags: got %b want 1001", status_out); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fwd_idle_valid: got %b want 0", out_valid); end
        n_vec++; if (datapath_out !== 32'h8000_0000) begin n_err++; $display("FAIL fwd_hold: got %h want 80000000", datapath_out); end
        reg_addr = 4'd2; #1;
        n_vec++; if (reg_output !== 32'h8000_0000) begin n_err++; $display("FAIL fwd_r2: got %h want 80000000", reg_output); end
    endtask

    task automatic test_cmp();
        logic [31:0] d, e;
        int lat, bb;
        @(negedge clk);
        step(OP_MOV, 3, 0, 0, 2'd0, 0, 1'b1, 32'd5, 1'b1, 1'b0, d, e, lat, bb);
        step(OP_CMP, 8, 3, 0, 2'd0, 0, 1'b1, 32'd5, 1'b1, 1'b0, d, e, lat, bb);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL cmp_result: got %h want 0", d); end
        @(negedge clk);
        n_vec++; if (status_out !== 4'b0110) begin n_err++; $display("FAIL cmp_flags: got %b want 0110", status_out); end
        reg_addr = 4'd3; #1;
        n_vec++; if (reg_output !== 32'd5) begin n_err++; $display("FAIL cmp_r3: got %h want 5", reg_output); end
        reg_addr = 4'd8; #1;
        n_vec++; if (reg_output !== m_regs[8]) begin n_err++; $display("FAIL cmp_r8: got %h want %h", reg_output, m_regs[8]); end
    endtask

    task automatic test_shifts();
        logic [31:0] d, e;
        int lat, bb;
        int          t_sop [9] = '{2, 3, 1, 0, 2, 3, 0, 2, 3};
        int          t_amt [9] = '{1, 1, 1, 0, 0, 0, 31, 31, 31};
        logic [31:0] t_exp [9] = '{32'hC000_0000, 32'hC000_0000, 32'h4000_0000, 32'h8000_0001,
                                   32'h8000_0001, 32'h8000_0001, 32'h8000_0000, 32'hFFFF_FFFF,
                                   32'h0000_0003};
        @(negedge clk);
        step(OP_MOV, 4, 0, 0, 2'd0, 0, 1'b1, 32'h8000_0001, 1'b1, 1'b0, d, e, lat, bb);
        for (int i = 0; i < 9; i++) begin
            step(OP_MOV, 9, 0, 4, 2'(t_sop[i]), t_amt[i], 1'b0, 32'd0, 1'b1, 1'b0, d, e, lat, bb);
            n_vec++;
            if (d !== t_exp[i]) begin
                n_err++;
                $display("FAIL shift sop=%0d amt=%0d: got %h want %h", t_sop[i], t_amt[i], d, t_exp[i]);
            end
        end
    endtask

    task automatic test_mul();
        logic [31:0] d, e, e_mul, e_add;
        int lat, bb, busy_bad;
        @(negedge clk);
        step(OP_MOV, 6, 0, 0, 2'd0, 0, 1'b1, 32'h0001_0000, 1'b1, 1'b0, d, e, lat, bb);
        step(OP_MOV, 7, 0, 0, 2'd0, 0, 1'b1, 32'h0001_0001, 1'b1, 1'b0, d, e, lat, bb);
        step(OP_ADD, 11, 2, 0, 2'd0, 0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, d, e, lat, bb);
        @(negedge clk);
        n_vec++; if (status_out !== 4'b0111) begin n_err++; $display("FAIL mul_preflags: got %b want 0111", status_out); end
        ALU_op = OP_MUL; w_addr = 4'd5; A_addr = 4'd6; B_addr = 4'd7; shift_op = 2'd0; shift_amt = 5'd0;
        sel_B = 1'b0; w_en = 1'b1; en_status = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        e_mul = ref_exec(OP_MUL, 5, 6, 7, 2'd0, 0, 1'b0, 32'd0, 1'b1, 1'b1);
        // Next request is presented during the busy window and must wait.
        ALU_op = OP_ADD; w_addr = 4'd12; A_addr = 4'd5; sel_B = 1'b1; imme_data = 32'd1;
        w_en = 1'b1; en_status = 1'b0;
        busy_bad = 0;
        for (int k = 1; k <= 31; k++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
            @(negedge clk);
        end
        n_vec++; if (busy_bad !== 0) begin n_err++; $display("FAIL mul_busy_window: got %0d bad cycles want 0", busy_bad); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mul_out_valid_t32: got %b want 1", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mul_in_ready_t32: got %b want 1", in_ready); end
        n_vec++; if (datapath_out !== 32'h0001_0000) begin n_err++; $display("FAIL mul_result: got %h want 00010000", datapath_out); end
        n_vec++; if (datapath_out !== e_mul) begin n_err++; $display("FAIL mul_model: got %h want %h", datapath_out, e_mul); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        e_add = ref_exec(OP_ADD, 12, 5, 0, 2'd0, 0, 1'b1, 32'd1, 1'b1, 1'b0);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mul_held_valid: got %b want 1", out_valid); end
        n_vec++; if (datapath_out !== e_add) begin n_err++; $display("FAIL mul_held_fwd: got %h want %h", datapath_out, e_add); end
        @(negedge clk);
        n_vec++; if (status_out !== 4'b0011) begin n_err++; $display("FAIL mul_flags: got %b want 0011", status_out); end
        reg_addr = 4'd5; #1;
        n_vec++; if (reg_output !== 32'h0001_0000) begin n_err++; $display("FAIL mul_r5: got %h want 00010000", reg_output); end
    endtask

    task automatic test_mul_reset();
        int ov_seen;
        @(negedge clk);
        ALU_op = OP_MUL; w_addr = 4'd5; A_addr = 4'd6; B_addr = 4'd7; shift_op = 2'd0; shift_amt = 5'd0;
        sel_B = 1'b0; w_en = 1'b1; en_status = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        ov_seen = 0;
        for (int k = 1; k < 10; k++) begin
            if (out_valid !== 1'b0) ov_seen++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ov_seen++;
        end
        rst_n = 1'b1;
        model_reset();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mulrst_in_ready: got %b want 1", in_ready); end
        for (int k = 0; k < 40; k++) begin
            if (out_valid !== 1'b0) ov_seen++;
            @(negedge clk);
        end
        n_vec++; if (ov_seen !== 0) begin n_err++; $display("FAIL mulrst_out_valid: got %0d valid cycles want 0", ov_seen); end
        n_vec++; if (status_out !== 4'b0000) begin n_err++; $display("FAIL mulrst_flags: got %b want 0000", status_out); end
        reg_addr = 4'd5; #1;
        n_vec++; if (reg_output !== 32'd0) begin n_err++; $display("FAIL mulrst_r5: got %h want 0", reg_output); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, e;
        int lat, bb;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            step(OP_ADD, 1, 1, 0, 2'd0, 0, 1'b1, $urandom, 1'b1, 1'b1, d, e, lat, bb);
            n_vec++; if (d !== e) begin n_err++; $display("FAIL b2b_%0d: got %h want %h", i, d, e); end
        end
        @(negedge clk);
        n_vec++; if (status_out !== m_flags) begin n_err++; $display("FAIL b2b_flags: got %b want %b", status_out, m_flags); end
        reg_addr = 4'd1; #1;
        n_vec++; if (reg_output !== m_regs[1]) begin n_err++; $display("FAIL b2b_r1: got %h want %h", reg_output, m_regs[1]); end
    endtask

    task automatic test_random();
        logic [31:0] d, e;
        int lat, bb, r;
        logic [2:0] op;
        @(negedge clk);
        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom_range(0, 7));
            if (op == OP_MUL && $urandom_range(0, 2) != 0) op = 3'($urandom_range(0, 6));
            step(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 2'($urandom_range(0, 3)), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                 $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), d, e, lat, bb);
            n_vec++; if (d !== e) begin n_err++; $display("FAIL rand_%0d op=%0d result: got %h want %h", i, op, d, e); end
            n_vec++;
            if (lat !== ((op == OP_MUL) ? 32 : 1)) begin
                n_err++; $display("FAIL rand_%0d op=%0d latency: got %0d want %0d", i, op, lat, (op == OP_MUL) ? 32 : 1);
            end
            if (op == OP_MUL) begin
                n_vec++; if (bb !== 0) begin n_err++; $display("FAIL rand_%0d mul_ready_low: got %0d bad cycles want 0", i, bb); end
            end
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                n_vec++; if (status_out !== m_flags) begin n_err++; $display("FAIL rand_%0d flags: got %b want %b", i, status_out, m_flags); end
                n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rand_%0d idle_valid: got %b want 0", i, out_valid); end
                n_vec++; if (datapath_out !== e) begin n_err++; $display("FAIL rand_%0d hold: got %h want %h", i, datapath_out, e); end
                r = $urandom_range(0, 15);
                reg_addr = 4'(r); #1;
                n_vec++; if (reg_output !== m_regs[r]) begin n_err++; $display("FAIL rand_%0d r%0d: got %h want %h", i, r, reg_output, m_regs[r]); end
            end
        end
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            reg_addr = 4'(i); #1;
            n_vec++; if (reg_output !== m_regs[i]) begin n_err++; $display("FAIL rand_final_r%0d: got %h want %h", i, reg_output, m_regs[i]); end
        end
        n_vec++; if (status_out !== m_flags) begin n_err++; $display("FAIL rand_final_flags: got %b want %b", status_out, m_flags); end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_forwarding();
        test_cmp();
        test_shifts();
        test_mul();
        test_mul_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/datapath_pipe.md
DATAPATH_PIPE -- requirements
Module: datapath_pipe

Interface
REQ-001 Parameter DATA_W, 32, operand/result/register width (8..64, power of two).
REQ-002 Parameter NREGS, 16, register-file depth (power of two); AW = clog2(NREGS), SW = clog2(DATA_W).
REQ-003 clk  in  1  single clock; all state changes on posedge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  issue request; in_ready  out  1  block can accept.
REQ-006 A_addr, B_addr  in  AW  source registers; w_addr  in  AW  destination register.
REQ-007 ALU_op  in  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MOV, 110 CMP, 111 MUL.
REQ-008 shift_op  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR; shift_amt  in  SW  shift amount applied to B.
REQ-009 sel_B  in  1  1 = operand B is imme_data, 0 = shifted register B; imme_data  in  DATA_W.
REQ-010 w_en  in  1  write result to w_addr; en_status  in  1  update flags.
REQ-011 out_valid  out  1  result valid; datapath_out  out  DATA_W  result.
REQ-012 status_out  out  4  flags {N,Z,C,V}.
REQ-013 reg_addr  in  AW, reg_output  out  DATA_W  combinational debug read of committed register state.

Function
REQ-014 Issue accepted on posedge where in_valid && in_ready; all issue inputs are sampled only at that edge.
REQ-015 Accepted issue latches operand A, operand B (after shift or immediate select) and the control fields into the execute stage.
REQ-016 Single-cycle ops (ADD..CMP), accepted at edge t: out_valid=1 and datapath_out=result throughout cycle t+1; register write and flag update at edge t+1.
REQ-017 out_valid is 0 in every cycle without a completing op; datapath_out holds its last value when out_valid=0.
REQ-018 Forwarding: a source read at issue matching the destination being written at the same edge returns the new result, never the stale register value.
REQ-019 ADD: A+B; C = carry out, V = signed overflow.
REQ-020 SUB/CMP: A-B computed as A+~B+1; C = carry out (1 = no borrow), V = signed overflow.
REQ-021 AND/ORR/EOR/MOV (MOV result = B): C and V preserved.
REQ-022 N = result[DATA_W-1], Z = (result==0), for every flag-updating op.
REQ-023 CMP: always updates flags and never writes a register, regardless of w_en/en_status.
REQ-024 Shifts use modulo-DATA_W amounts; amount 0 passes B unchanged for all shift_op; ASR sign-fills; ROR rotates.
REQ-025 FSM states RUN, MUL_BUSY; reset enters RUN; in_ready=1 in RUN, 0 in MUL_BUSY.
REQ-026 MUL accepted at edge t: RUN->MUL_BUSY; iterative shift-add, one multiplier bit per cycle, counter 0..DATA_W-1.
REQ-027 MUL result = low DATA_W bits of A*B; out_valid in cycle t+DATA_W; MUL_BUSY->RUN so in_ready=1 in that same cycle; write/flags at edge t+DATA_W.
REQ-028 MUL flags: N, Z only; C, V preserved.
REQ-029 Issue arriving with in_ready=0 is not accepted and leaves no trace; the requester holds it.
REQ-030 A write to register r and a reg_addr=r debug read in the same cycle return the old value; new value appears the next cycle.
REQ-031 w_en=0 suppresses register write only; out_valid and flags still behave per REQ-016..028.

Reset
REQ-032 While rst_n=0 at a posedge: all registers 0, status_out=4'b0000, out_valid=0, datapath_out=0, state RUN, MUL counter 0.
REQ-033 Reset during MUL_BUSY aborts the multiply: no write, no flag update, no out_valid; in_ready=1 from the first cycle after reset.
REQ-034 Issue inputs are ignored on any edge with rst_n=0.

Verification (DATA_W=32, NREGS=16)
REQ-035 Reset, read all 16 via reg_addr -> all 0; status_out=0000, in_ready=1, out_valid=0.
REQ-036 MOV r1,#0x7FFFFFFF; ADD r2,r1,#1 with en_status, back-to-back -> r2=0x80000000 via forwarding, NZCV=1001.
REQ-037 r3=5, CMP r3,#5 with w_en=1 -> NZCV=0110, r3 unchanged, w_addr register unchanged.
REQ-038 r4=0x80000001 as B: ASR 1 -> 0xC0000000; ROR 1 -> 0xC0000000; LSR 1 -> 0x40000000; LSL 0 -> 0x80000001.
REQ-039 MUL r5=r6*r7 with r6=0x10000, r7=0x10001 -> in_ready low cycles t+1..t+31, out_valid at t+32, r5=0x00010000, C/V unchanged; issue held during busy accepted at t+32.
REQ-040 Reset asserted at cycle t+10 of a MUL -> r5 = 0, out_valid never 1, in_ready=1 after reset.
